// File: rtl/basic_div.sv
// Iterative radix-2 restoring signed divider: DW-bit dividend / VW-bit divisor, C truncation semantics.
// Define BASIC_DIV_SAT_EN to saturate the quotient (and raise ovf) for the -2^(DW-1) / -1 case.
module basic_div #(
    parameter int DW = 45,
    parameter int VW = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [DW-1:0] dividend,
    input  logic signed [VW-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic signed [DW-1:0] quot,
    output logic signed [VW-1:0] rem,
    output logic                 dz,
    output logic                 ovf
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW:0]   prem_q, prem_d;
    logic          dvd_neg_q, dvd_neg_d;
    logic          dvs_neg_q, dvs_neg_d;
    logic          zero_q, zero_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dz_q, dz_d;
    logic          done_q, done_d;
    logic [VW+1:0] shifted;
    logic [VW:0]   diff;
    logic          take;
`ifdef BASIC_DIV_SAT_EN
    logic          ovf_flag_q, ovf_flag_d;
    logic          ovf_q, ovf_d;
`endif

    // dvd_q shifts out dividend magnitude bits at the top and collects quotient bits at the bottom
    always_comb begin
        shifted   = {prem_q, dvd_q[DW-1]};
        take      = (shifted >= {2'b00, dvs_q});
        diff      = shifted[VW:0] - {1'b0, dvs_q};
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        zero_d    = zero_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
`ifdef BASIC_DIV_SAT_EN
        ovf_flag_d = ovf_flag_q;
        ovf_d      = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d     = dividend[DW-1] ? $unsigned(-dividend) : $unsigned(dividend);
                    dvs_d     = divisor[VW-1] ? $unsigned(-divisor) : $unsigned(divisor);
                    dvd_neg_d = dividend[DW-1];
                    dvs_neg_d = divisor[VW-1];
                    zero_d    = (divisor == '0);
                    prem_d    = '0;
                    cnt_d     = '0;
                    state_d   = CALC;
`ifdef BASIC_DIV_SAT_EN
                    ovf_flag_d = (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
`endif
                end
            end
            CALC: begin
                prem_d = take ? diff : shifted[VW:0];
                dvd_d  = {dvd_q[DW-2:0], take};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = (dvd_neg_q ^ dvs_neg_q) ? -dvd_q : dvd_q;
                rem_d   = dvd_neg_q ? -prem_q[VW-1:0] : prem_q[VW-1:0];
                dz_d    = zero_q;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
                if (zero_q) begin
                    quot_d = '1;
                    rem_d  = '0;
                end
`ifdef BASIC_DIV_SAT_EN
                ovf_d = ovf_flag_q && !zero_q;
                if (ovf_flag_q && !zero_q) begin
                    quot_d = {1'b0, {(DW-1){1'b1}}};
                    rem_d  = '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
`ifdef BASIC_DIV_SAT_EN
            ovf_flag_q <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            zero_q    <= zero_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
`ifdef BASIC_DIV_SAT_EN
            ovf_flag_q <= ovf_flag_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign quot = quot_q;
    assign rem  = rem_q;
    assign dz   = dz_q;
`ifdef BASIC_DIV_SAT_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_basic_div.sv
// Scoreboard bench for basic_div: expected results queued at acceptance, compared when done pulses.
module tb_basic_div;

    localparam int DW = 45;
    localparam int VW = 18;
    localparam int LAT = DW + 1;
    localparam longint MIN_DVD = -(longint'(1) << (DW - 1));

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
        logic          ovf;
        int            acc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic signed [DW-1:0] dividend;
    logic signed [VW-1:0] divisor;
    logic                 busy;
    logic                 done;
    logic [DW-1:0]        quot;
    logic [VW-1:0]        rem;
    logic                 dz;
    logic                 ovf;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prevDone = 1'b0;
    exp_t sb[$];

    basic_div #(.DW(DW), .VW(VW)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quot(quot), .rem(rem), .dz(dz), .ovf(ovf)
    );

    // Free-running clock and an edge counter used to measure latency
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Reference division with C truncation plus the zero-divisor and overflow rules
    function automatic exp_t modelDiv(input logic signed [DW-1:0] a, input logic signed [VW-1:0] b);
        exp_t   e;
        longint la = longint'(a);
        longint lb = longint'(b);
        longint lq;
        longint lr;
        e.acc = 0;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (lb == 0) begin
            e.q  = '1;
            e.r  = '0;
            e.dz = 1'b1;
        end else if (la == MIN_DVD && lb == -1) begin
`ifdef BASIC_DIV_SAT_EN
            e.q   = {1'b0, {(DW-1){1'b1}}};
            e.ovf = 1'b1;
`else
            e.q   = {1'b1, {(DW-1){1'b0}}};
`endif
            e.r = '0;
        end else begin
            lq  = la / lb;
            lr  = la % lb;
            e.q = lq[DW-1:0];
            e.r = lr[VW-1:0];
        end
        return e;
    endfunction

    // Caller must be just past a negedge with the DUT idle or in its done cycle
    task automatic applyStimulus(input logic signed [DW-1:0] a, input logic signed [VW-1:0] b,
                                 input logic [DW-1:0] eq, input logic [VW-1:0] er,
                                 input logic edz, input logic eovf);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        e.q = eq; e.r = er; e.dz = edz; e.ovf = eovf; e.acc = cyc;
        sb.push_back(e);
        checkOutput("busy_after_start", 64'(busy), 64'(1));
        start = 1'b0;
    endtask

    task automatic applyModel(input logic signed [DW-1:0] a, input logic signed [VW-1:0] b);
        exp_t e = modelDiv(a, b);
        applyStimulus(a, b, e.q, e.r, e.dz, e.ovf);
    endtask

    task automatic waitDone();
        int n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) checkOutput("done_timeout", 64'(0), 64'(1));
    endtask

    // Compare every done pulse against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (prevDone) checkOutput("done_pulse_width", 64'(prevDone), 64'(0));
            checkOutput("busy_in_done", 64'(busy), 64'(0));
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 64'(done), 64'(0));
            end else begin
                e = sb.pop_front();
                checkOutput("quot", 64'(quot), 64'(e.q));
                checkOutput("rem", 64'(rem), 64'(e.r));
                checkOutput("dz", 64'(dz), 64'(e.dz));
                checkOutput("ovf", 64'(ovf), 64'(e.ovf));
                checkOutput("latency", 64'(cyc - e.acc), 64'(LAT));
            end
        end
        prevDone = done;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] rnd;
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 45'sd100;
        divisor  = 18'sd7;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_quot", 64'(quot), 64'(0));
        checkOutput("reset_rem", 64'(rem), 64'(0));
        checkOutput("reset_dz", 64'(dz), 64'(0));
        checkOutput("reset_ovf", 64'(ovf), 64'(0));
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        applyStimulus(45'sd100, 18'sd7, 45'sd14, 18'sd2, 1'b0, 1'b0);
        waitDone();
        applyStimulus(-45'sd100, 18'sd7, -45'sd14, -18'sd2, 1'b0, 1'b0);
        waitDone();
        applyStimulus(45'sd100, -18'sd7, -45'sd14, 18'sd2, 1'b0, 1'b0);
        waitDone();
        applyStimulus(-45'sd100, -18'sd7, 45'sd14, -18'sd2, 1'b0, 1'b0);
        waitDone();
        applyStimulus(45'sd0, 18'sd5, 45'sd0, 18'sd0, 1'b0, 1'b0);
        waitDone();
        applyStimulus(45'sd5, 18'h20000, 45'sd0, 18'sd5, 1'b0, 1'b0);
        waitDone();
        applyStimulus(45'sd55, 18'sd0, '1, 18'sd0, 1'b1, 1'b0);
        waitDone();
        applyStimulus(45'sd21, 18'sd4, 45'sd5, 18'sd1, 1'b0, 1'b0);
        waitDone();
`ifdef BASIC_DIV_SAT_EN
        applyStimulus(45'h100000000000, -18'sd1, 45'hFFFFFFFFFFF, 18'sd0, 1'b0, 1'b1);
`else
        applyStimulus(45'h100000000000, -18'sd1, 45'h100000000000, 18'sd0, 1'b0, 1'b0);
`endif
        waitDone();

        // start held high while busy must be ignored
        applyStimulus(45'sd9, 18'sd3, 45'sd3, 18'sd0, 1'b0, 1'b0);
        dividend = 45'sd50;
        divisor  = 18'sd5;
        start    = 1'b1;
        repeat (9) @(negedge clk);
        start = 1'b0;
        waitDone();
        applyStimulus(45'sd50, 18'sd5, 45'sd10, 18'sd0, 1'b0, 1'b0);
        waitDone();

        // mid-operation reset aborts without a done pulse
        applyStimulus(45'sd1000, 18'sd3, 45'sd333, 18'sd1, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        checkOutput("abort_quot", 64'(quot), 64'(0));
        checkOutput("abort_rem", 64'(rem), 64'(0));
        checkOutput("abort_dz", 64'(dz), 64'(0));
        checkOutput("abort_ovf", 64'(ovf), 64'(0));
        repeat (60) @(negedge clk);
        applyStimulus(45'sd1000, 18'sd3, 45'sd333, 18'sd1, 1'b0, 1'b0);
        waitDone();

        for (int i = 0; i < 12; i++) begin
            rnd = {$urandom, $urandom};
            if (i % 3 == 0) applyModel(DW'(rnd), VW'($urandom_range(0, 40)) - VW'(20));
            else            applyModel(DW'(rnd), VW'($urandom));
            waitDone();
        end
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
